// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : td4_pkg
//  Description : Shared encodings for the TD4 execution sequencer. Holds the
//                host command opcodes, the sequencer state encoding, the
//                jump opcode and the bit ranges of the instruction fields.
//                Each instruction byte is laid out as {opcode, immediate}.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef TD4_PKG_FIELDS
`define TD4_PKG_FIELDS
// Bit ranges of the two fields inside an 8-bit instruction byte.
`define TD4_OPC_FIELD 7:4
`define TD4_IMM_FIELD 3:0
`endif

package td4_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_STOP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_e;

  // "JMP imm": an unconditional jump to its own address is the halt idiom.
  localparam logic [3:0] OPC_JMP = 4'b1111;

  localparam int unsigned PROG_DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/td4_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : td4_prog_mem
//  Description : 16 x 8 program store for the TD4 core. Synchronous write,
//                asynchronous (combinational) read. Every byte returns to
//                MEM_INIT while rst_n is low.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                we     - write enable
//                waddr  - write address
//                wdata  - write data
//                raddr  - read address
//                rdata  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_prog_mem
  import td4_pkg::*;
#(
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  // All bytes flattened into one vector so each byte has a single driver.
  logic [8*PROG_DEPTH-1:0] mem_flat;

  generate
    for (genvar i = 0; i < PROG_DEPTH; i++) begin : g_byte
      logic [7:0] byte_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_q <= MEM_INIT;
        end else if (we && (waddr == 4'(i))) begin
          byte_q <= wdata;
        end
      end

      assign mem_flat[8*i +: 8] = byte_q;
    end
  endgenerate

  assign rdata = mem_flat[{raddr, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/td4_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : td4_exec_sequencer
//  Description : Host-side controller for the 4-bit TD4 core. Owns the program
//                store, presents opcode/immediate for the core's current PC and
//                sequences single-cycle exec_mode strobes for RUN, STEP and
//                STOP commands. Detects the "JMP to self" halt idiom.
//  Config      : TD4_BREAKPOINT_EN - when defined, RUN halts before fetching
//                the instruction at bp_addr (resume executes it first).
//  Ports       : clk        - clock
//                rst_n      - asynchronous active-low reset
//                cmd_valid  - host command strobe
//                cmd_op     - 00 LOAD, 01 RUN, 10 STEP, 11 STOP
//                ld_addr    - LOAD address
//                ld_data    - LOAD byte {opcode, immediate}
//                bp_addr    - breakpoint address (breakpoint builds only)
//                pc_in      - current PC from the core
//                opcode     - mem[pc_in][7:4]
//                immediate  - mem[pc_in][3:0]
//                exec_mode  - one-cycle strobe, core executes on next edge
//                state      - 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//                halted     - high while HALTED
//                cmd_err    - one-cycle pulse when a command is rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_exec_sequencer
  import td4_pkg::*;
#(
  parameter int         RUN_DIV  = 4,
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [3:0] bp_addr,
  input  logic [3:0] pc_in,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       exec_mode,
  output logic [1:0] state,
  output logic       halted,
  output logic       cmd_err
);

  // A divide of at least 2 keeps strobes from landing on adjacent cycles.
  localparam int         DIV_EFF  = (RUN_DIV < 2) ? 2 : ((RUN_DIV > 255) ? 255 : RUN_DIV);
  localparam logic [7:0] DIV_LAST = 8'(DIV_EFF - 1);

  seq_state_e state_q;
  logic [7:0] div_q;
  logic       exec_q;
  logic       err_q;
  logic [7:0] instr;
  cmd_op_e    op;
  logic       ctl_idle;
  logic       mem_we;
  logic       halt_hit;
  logic       bp_hit;

  assign op       = cmd_op_e'(cmd_op);
  assign ctl_idle = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign mem_we   = cmd_valid && (op == CMD_LOAD) && ctl_idle;

  td4_prog_mem #(
    .MEM_INIT (MEM_INIT)
  ) u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (pc_in),
    .rdata (instr)
  );

  assign opcode    = instr[`TD4_OPC_FIELD];
  assign immediate = instr[`TD4_IMM_FIELD];

  // The strobe currently on exec_mode is a jump to its own address.
  assign halt_hit = exec_q && (opcode == OPC_JMP) && (immediate == pc_in);

`ifdef TD4_BREAKPOINT_EN
  // Set on resume from HALTED so the instruction at bp_addr runs once.
  logic bp_skip_q;
  assign bp_hit = (pc_in == bp_addr) && !bp_skip_q;
`else
  logic unused_bp;
  assign unused_bp = ^bp_addr;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      exec_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef TD4_BREAKPOINT_EN
      bp_skip_q <= 1'b0;
`endif
    end else begin
      // Both outputs are single-cycle pulses unless re-asserted below.
      exec_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (cmd_valid) begin
            case (op)
              CMD_RUN: begin
                state_q <= ST_RUN;
                div_q   <= 8'd0;
`ifdef TD4_BREAKPOINT_EN
                bp_skip_q <= (state_q == ST_HALTED);
`endif
              end
              CMD_STEP: state_q <= ST_STEP;
              CMD_STOP: state_q <= ST_IDLE;
              CMD_LOAD: ;
            endcase
          end
        end

        ST_RUN: begin
          // STOP beats halt detection and suppresses any pending strobe.
          if (cmd_valid && (op == CMD_STOP)) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
          end else begin
            if (cmd_valid) begin
              err_q <= 1'b1;
            end
            if (halt_hit) begin
              state_q <= ST_HALTED;
              div_q   <= 8'd0;
            end else if (div_q == DIV_LAST) begin
              div_q <= 8'd0;
              if (bp_hit) begin
                state_q <= ST_HALTED;
              end else begin
                exec_q <= 1'b1;
`ifdef TD4_BREAKPOINT_EN
                bp_skip_q <= 1'b0;
`endif
              end
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end

        ST_STEP: begin
          if (cmd_valid && (op == CMD_STOP)) begin
            state_q <= ST_IDLE;
          end else begin
            if (cmd_valid) begin
              err_q <= 1'b1;
            end
            // First STEP cycle issues the strobe, second cycle retires it.
            if (!exec_q) begin
              exec_q <= 1'b1;
            end else begin
              state_q <= halt_hit ? ST_HALTED : ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exec_mode = exec_q;
  assign cmd_err   = err_q;
  assign state     = state_q;
  assign halted    = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_td4_exec_sequencer.sv
`timescale 1ns/1ps
module tb_td4_exec_sequencer;

  localparam int         RUN_DIV  = 4;
  localparam logic [7:0] MEM_INIT = 8'h3C;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_STEP   = 2'b10;
  localparam logic [1:0] S_HALTED = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] ld_addr = 4'h0;
  logic [7:0] ld_data = 8'h00;
  logic [3:0] bp_addr = 4'hF;
  logic [3:0] pc_in;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       exec_mode;
  logic [1:0] state;
  logic       halted;
  logic       cmd_err;

  // Core model: PC register, optional override for direct memory reads.
  logic [3:0] pc_reg;
  logic       pc_clear = 1'b1;
  logic       pc_ovr = 1'b0;
  logic [3:0] pc_ovr_val = 4'h0;

  int tests = 0;
  int fails = 0;
  int k;
  int cnt;
  logic [7:0] shadow [16];

  td4_exec_sequencer #(
    .RUN_DIV  (RUN_DIV),
    .MEM_INIT (MEM_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .bp_addr   (bp_addr),
    .pc_in     (pc_in),
    .opcode    (opcode),
    .immediate (immediate),
    .exec_mode (exec_mode),
    .state     (state),
    .halted    (halted),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  assign pc_in = pc_ovr ? pc_ovr_val : pc_reg;

  // The core executes the presented instruction on the edge after a strobe:
  // JMP loads the immediate, anything else advances the PC.
  always @(posedge clk) begin
    if (pc_clear) pc_reg <= 4'h0;
    else if (exec_mode) pc_reg <= (opcode == 4'hF) ? immediate : pc_reg + 4'h1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is sampled on the next posedge and the
  // task returns at the negedge right after that edge.
  task automatic cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    ld_addr   = a;
    ld_data   = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_pc();
    pc_clear = 1'b1;
    @(negedge clk);
    pc_clear = 1'b0;
  endtask

  // Program in shadow runs straight from 0 to a JMP-to-self at address kk.
  // Reference: strobe n (n = 0..kk) appears RUN_DIV*(n+1) cycles after RUN is
  // accepted, fetching address n; afterwards HALTED with PC parked at kk.
  task automatic run_to_halt(input int kk, input string tag);
    cmd(OP_RUN, 4'h0, 8'h00);
    for (int c = 1; c <= (kk + 1) * RUN_DIV + 3; c++) begin
      @(negedge clk);
      if ((c % RUN_DIV == 0) && (c <= (kk + 1) * RUN_DIV)) begin
        check({tag, " strobe"}, 32'(exec_mode), 32'd1);
        check({tag, " strobe pc"}, 32'(pc_in), 32'(c / RUN_DIV - 1));
        check({tag, " fetch"}, 32'({opcode, immediate}), 32'(shadow[c / RUN_DIV - 1]));
      end else begin
        check({tag, " no strobe"}, 32'(exec_mode), 32'd0);
      end
    end
    check({tag, " state halted"}, 32'(state), 32'(S_HALTED));
    check({tag, " halted flag"}, 32'(halted), 32'd1);
    check({tag, " final pc"}, 32'(pc_in), 32'(kk));
  endtask

  initial begin
    for (int a = 0; a < 16; a++) shadow[a] = MEM_INIT;

    // ---------------- reset values
    repeat (2) @(negedge clk);
    check("reset state", 32'(state), 32'(S_IDLE));
    check("reset exec_mode", 32'(exec_mode), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset cmd_err", 32'(cmd_err), 32'd0);
    check("reset mem[0]", 32'({opcode, immediate}), 32'(MEM_INIT));
    rst_n = 1'b1;
    @(negedge clk);
    pc_clear = 1'b0;

    // ---------------- directed program with JMP-to-self at 3
    shadow[0] = 8'hC5; shadow[1] = 8'h03; shadow[2] = 8'hD0; shadow[3] = 8'hF3;
    for (int a = 0; a < 4; a++) cmd(OP_LOAD, 4'(a), shadow[a]);
    check("load keeps idle", 32'(state), 32'(S_IDLE));
    run_to_halt(3, "prog1");
    cmd(OP_STOP, 4'h0, 8'h00);
    check("stop from halted state", 32'(state), 32'(S_IDLE));
    check("stop clears halted", 32'(halted), 32'd0);

    // ---------------- three single steps
    clear_pc();
    for (int i = 0; i < 3; i++) begin
      cmd(OP_STEP, 4'h0, 8'h00);
      check("step entry state", 32'(state), 32'(S_STEP));
      check("step entry exec", 32'(exec_mode), 32'd0);
      @(negedge clk);
      check("step strobe", 32'(exec_mode), 32'd1);
      check("step strobe pc", 32'(pc_in), 32'(i));
      @(negedge clk);
      check("step done exec", 32'(exec_mode), 32'd0);
      check("step done state", 32'(state), 32'(S_IDLE));
      check("step pc advanced", 32'(pc_in), 32'(i + 1));
    end

    // ---------------- rejected commands while running
    clear_pc();
    cmd(OP_RUN, 4'h0, 8'h00);
    cmd(OP_LOAD, 4'h5, 8'h77);
    check("load in run err", 32'(cmd_err), 32'd1);
    check("load in run state", 32'(state), 32'(S_RUN));
    @(negedge clk);
    check("err is one pulse", 32'(cmd_err), 32'd0);
    cmd(OP_STEP, 4'h0, 8'h00);
    check("step in run err", 32'(cmd_err), 32'd1);
    check("step in run state", 32'(state), 32'(S_RUN));
    cmd(OP_STOP, 4'h0, 8'h00);
    check("stop from run", 32'(state), 32'(S_IDLE));
    check("stop no err", 32'(cmd_err), 32'd0);
    pc_ovr = 1'b1; pc_ovr_val = 4'h5;
    #1;
    check("mem[5] unchanged", 32'({opcode, immediate}), 32'(shadow[5]));
    pc_ovr = 1'b0;
    @(negedge clk);

    // ---------------- STOP on the divider terminal edge
    clear_pc();
    cmd(OP_RUN, 4'h0, 8'h00);
    cnt = 0;
    repeat (RUN_DIV - 1) begin
      @(negedge clk);
      if (exec_mode) cnt++;
    end
    cmd(OP_STOP, 4'h0, 8'h00);
    if (exec_mode) cnt++;
    check("stop on terminal state", 32'(state), 32'(S_IDLE));
    repeat (2 * RUN_DIV) begin
      @(negedge clk);
      if (exec_mode) cnt++;
    end
    check("stop on terminal <=1 strobe", 32'(cnt <= 1), 32'd1);
    check("stop on terminal idle after", 32'(exec_mode), 32'd0);
    check("stop on terminal stays idle", 32'(state), 32'(S_IDLE));

    // ---------------- randomized straight-line programs
    for (int r = 0; r < 4; r++) begin
      clear_pc();
      k = $urandom_range(3, 9);
      for (int a = 0; a < 16; a++) begin
        if (a < k) shadow[a] = {4'($urandom_range(0, 14)), 4'($urandom)};
        else if (a == k) shadow[a] = {4'hF, 4'(k)};
        else shadow[a] = 8'($urandom);
        cmd(OP_LOAD, 4'(a), shadow[a]);
      end
      run_to_halt(k, "random");
      cmd(OP_STOP, 4'h0, 8'h00);
    end

    // ---------------- asynchronous reset in the middle of RUN
    clear_pc();
    cmd(OP_RUN, 4'h0, 8'h00);
    repeat (RUN_DIV) @(negedge clk);
    check("pre-reset strobe", 32'(exec_mode), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset exec", 32'(exec_mode), 32'd0);
    check("async reset state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    pc_ovr = 1'b1;
    for (int a = 0; a < 16; a++) begin
      pc_ovr_val = 4'(a);
      #1;
      check("mem reinit", 32'({opcode, immediate}), 32'(MEM_INIT));
      shadow[a] = MEM_INIT;
    end
    pc_ovr = 1'b0;
    @(negedge clk);
    check("post reset idle", 32'(state), 32'(S_IDLE));

`ifdef TD4_BREAKPOINT_EN
    // ---------------- breakpoint at 2 inside a 0..3 loop
    clear_pc();
    bp_addr = 4'h2;
    shadow[0] = 8'h01; shadow[1] = 8'h01; shadow[2] = 8'h01; shadow[3] = 8'hF0;
    for (int a = 0; a < 4; a++) cmd(OP_LOAD, 4'(a), shadow[a]);
    cmd(OP_RUN, 4'h0, 8'h00);
    for (int c = 1; c <= 3 * RUN_DIV + 2; c++) begin
      @(negedge clk);
      check("bp first run strobe", 32'(exec_mode), 32'((c == RUN_DIV) || (c == 2 * RUN_DIV)));
    end
    check("bp halted", 32'(state), 32'(S_HALTED));
    check("bp halted pc", 32'(pc_in), 32'd2);
    cmd(OP_RUN, 4'h0, 8'h00);
    for (int c = 1; c <= 5 * RUN_DIV + 2; c++) begin
      @(negedge clk);
      check("bp resume strobe", 32'(exec_mode), 32'((c % RUN_DIV == 0) && (c <= 4 * RUN_DIV)));
      if (c == RUN_DIV) check("bp resume pc", 32'(pc_in), 32'd2);
      if (c == 2 * RUN_DIV) check("bp resume next pc", 32'(pc_in), 32'd3);
    end
    check("bp halted again", 32'(state), 32'(S_HALTED));
    check("bp halted again pc", 32'(pc_in), 32'd2);
    bp_addr = 4'hF;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
